// File: rtl/project_pkg.sv
// Shared core definitions: opcode field layout, opcode classification helpers
// and the fetch sequencer state encoding.
package project_pkg;

  // Opcode lives in the upper nibble; bit 7 marks the two-byte (immediate) class.
  localparam int          OP_HI   = 7;
  localparam int          OP_LO   = 4;
  localparam int          IMM_BIT = 7;
  localparam logic [3:0]  OP_HLT  = 4'h7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  function automatic logic op_has_imm(input logic [7:0] instr);
    return instr[IMM_BIT];
  endfunction

  function automatic logic op_is_halt(input logic [7:0] instr);
    return instr[OP_HI:OP_LO] == OP_HLT;
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: owns the PC, reads opcode+immediate from the
// combinational ROM and hands one instruction bundle at a time to decode.
module instr_fetch
  import project_pkg::*;
#(
  parameter int              WORD     = 8,
  parameter logic [WORD-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            jmp_en,
  input  logic [WORD-1:0] jmp_addr,
  output logic [WORD-1:0] mem_addr,
  input  logic [WORD-1:0] mem_instr,
  input  logic [WORD-1:0] mem_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WORD-1:0] out_instr,
  output logic [WORD-1:0] out_imm,
  output logic            out_has_imm,
  output logic [WORD-1:0] out_pc,
  output logic            halted
);

  localparam logic [WORD-1:0] STEP_ONE = WORD'(1);
  localparam logic [WORD-1:0] STEP_TWO = WORD'(2);

  fetch_state_e    state_q, state_d;
  logic [WORD-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic [WORD-1:0] instr_q, instr_d;
  logic [WORD-1:0] imm_q, imm_d;
  logic            has_imm_q, has_imm_d;
  logic [WORD-1:0] opc_q, opc_d;

  logic cur_has_imm;
  logic cur_is_halt;
  logic load;

  assign cur_has_imm = op_has_imm(mem_instr[7:0]);
  assign cur_is_halt = op_is_halt(mem_instr[7:0]);
  assign load        = (state_q == RUN) && !jmp_en && (!valid_q || out_ready);

  always_comb begin
    // NOTE: every next-state value gets its hold default first so no path
    // through the branches below can infer a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    imm_d     = imm_q;
    has_imm_d = has_imm_q;
    opc_d     = opc_q;

    if (jmp_en && state_q != IDLE) begin
      // Redirect discards any pending bundle and takes priority over start/load.
      pc_d    = jmp_addr;
      valid_d = 1'b0;
      state_d = RUN;
    end else begin
      unique case (state_q)
        IDLE: if (start) state_d = RUN;
        RUN: begin
          if (load) begin
            instr_d   = mem_instr;
            opc_d     = pc_q;
            has_imm_d = cur_has_imm;
            imm_d     = cur_has_imm ? mem_imm : '0;
            valid_d   = 1'b1;
            pc_d      = pc_q + (cur_has_imm ? STEP_TWO : STEP_ONE);
            if (cur_is_halt) state_d = HALT;
          end
        end
        HALT: if (start) state_d = RUN;
        default: state_d = IDLE;
      endcase

      // Outside RUN nothing refills, so an accepted bundle simply drains.
      if (state_q != RUN && valid_q && out_ready) valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      valid_q   <= 1'b0;
      instr_q   <= '0;
      imm_q     <= '0;
      has_imm_q <= 1'b0;
      opc_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      imm_q     <= imm_d;
      has_imm_q <= has_imm_d;
      opc_q     <= opc_d;
    end
  end

  assign mem_addr    = pc_q;
  assign out_valid   = valid_q;
  assign out_instr   = instr_q;
  assign out_imm     = imm_q;
  assign out_has_imm = has_imm_q;
  assign out_pc      = opc_q;
  assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, stall, halt/resume, redirect,
// address wrap and reset during stall, against hand-computed bundles.
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       jmp_en;
  logic [7:0] jmp_addr;
  logic [7:0] mem_addr;
  logic [7:0] mem_instr;
  logic [7:0] mem_imm;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_instr;
  logic [7:0] out_imm;
  logic       out_has_imm;
  logic [7:0] out_pc;
  logic       halted;

  logic [7:0] rom [256];
  logic [7:0] imm_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imm_addr  = mem_addr + 8'd1;
  assign mem_instr = rom[mem_addr];
  assign mem_imm   = rom[imm_addr];

  instr_fetch #(.WORD(8), .RESET_PC(8'h00)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .jmp_en     (jmp_en),
    .jmp_addr   (jmp_addr),
    .mem_addr   (mem_addr),
    .mem_instr  (mem_instr),
    .mem_imm    (mem_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_imm    (out_imm),
    .out_has_imm(out_has_imm),
    .out_pc     (out_pc),
    .halted     (halted)
  );

  // Observed vector: {valid, pc, instr, imm, has_imm, halted, mem_addr}.
  function automatic logic [34:0] observe();
    return {out_valid, out_pc, out_instr, out_imm, out_has_imm, halted, mem_addr};
  endfunction

  function automatic logic [34:0] bundle(input logic v, input logic [7:0] pc,
                                         input logic [7:0] ins, input logic [7:0] imm,
                                         input logic hi, input logic h, input logic [7:0] ma);
    return {v, pc, ins, imm, hi, h, ma};
  endfunction

  task automatic cyc(input logic s, input logic j, input logic [7:0] ja, input logic rdy);
    start     = s;
    jmp_en    = j;
    jmp_addr  = ja;
    out_ready = rdy;
    @(posedge clk);
    #1;
    start  = 1'b0;
    jmp_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [34:0] o;
    rst_n = 1'b0;
    cyc(1'b1, 1'b1, 8'h55, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    o = observe();
    checks++;
    if (o !== bundle(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00)) begin
      errors++;
      $display("FAIL reset: got %h required %h", o, bundle(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00));
    end
    rst_n = 1'b1;
  endtask

  task automatic test_stream_stall();
    logic [34:0] exp_v [7];
    logic        rdy   [7];
    logic [34:0] o;
    exp_v[0] = bundle(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00); rdy[0] = 1'b1; // start edge
    exp_v[1] = bundle(1'b1, 8'h00, 8'h01, 8'h00, 1'b0, 1'b0, 8'h01); rdy[1] = 1'b1;
    exp_v[2] = bundle(1'b1, 8'h01, 8'h80, 8'hFF, 1'b1, 1'b0, 8'h03); rdy[2] = 1'b1;
    exp_v[3] = exp_v[2];                                              rdy[3] = 1'b0;
    exp_v[4] = exp_v[2];                                              rdy[4] = 1'b0;
    exp_v[5] = exp_v[2];                                              rdy[5] = 1'b0;
    exp_v[6] = bundle(1'b1, 8'h03, 8'h30, 8'h00, 1'b0, 1'b0, 8'h04); rdy[6] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cyc(i == 0, 1'b0, 8'h00, rdy[i]);
      o = observe();
      checks++;
      if (o !== exp_v[i]) begin
        errors++;
        $display("FAIL stream[%0d]: got %h required %h", i, o, exp_v[i]);
      end
    end
  endtask

  task automatic test_halt();
    logic [34:0] exp_v [6];
    logic        st    [6];
    logic [34:0] o;
    exp_v[0] = bundle(1'b1, 8'h04, 8'h02, 8'h00, 1'b0, 1'b0, 8'h05); st[0] = 1'b0;
    exp_v[1] = bundle(1'b1, 8'h05, 8'h70, 8'h00, 1'b0, 1'b1, 8'h06); st[1] = 1'b0;
    exp_v[2] = bundle(1'b0, 8'h05, 8'h70, 8'h00, 1'b0, 1'b1, 8'h06); st[2] = 1'b0;
    exp_v[3] = exp_v[2];                                              st[3] = 1'b0;
    exp_v[4] = bundle(1'b0, 8'h05, 8'h70, 8'h00, 1'b0, 1'b0, 8'h06); st[4] = 1'b1;
    exp_v[5] = bundle(1'b1, 8'h06, 8'h30, 8'h00, 1'b0, 1'b0, 8'h07); st[5] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(st[i], 1'b0, 8'h00, 1'b1);
      o = observe();
      checks++;
      if (o !== exp_v[i]) begin
        errors++;
        $display("FAIL halt[%0d]: got %h required %h", i, o, exp_v[i]);
      end
    end
  endtask

  task automatic test_redirect();
    logic [34:0] o;
    logic [34:0] e;
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    o = observe(); e = bundle(1'b1, 8'h06, 8'h30, 8'h00, 1'b0, 1'b0, 8'h07);
    checks++;
    if (o !== e) begin errors++; $display("FAIL redir_stall: got %h required %h", o, e); end
    cyc(1'b1, 1'b1, 8'h10, 1'b0);
    o = observe(); e = bundle(1'b0, 8'h06, 8'h30, 8'h00, 1'b0, 1'b0, 8'h10);
    checks++;
    if (o !== e) begin errors++; $display("FAIL redir_bubble: got %h required %h", o, e); end
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    o = observe(); e = bundle(1'b1, 8'h10, 8'h31, 8'h00, 1'b0, 1'b0, 8'h11);
    checks++;
    if (o !== e) begin errors++; $display("FAIL redir_target: got %h required %h", o, e); end
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    o = observe(); e = bundle(1'b1, 8'h11, 8'h70, 8'h00, 1'b0, 1'b1, 8'h12);
    checks++;
    if (o !== e) begin errors++; $display("FAIL redir_hlt: got %h required %h", o, e); end
    // start and jmp_en together from HALT: the jump target must win over PC 0x12.
    cyc(1'b1, 1'b1, 8'hFF, 1'b0);
    o = observe(); e = bundle(1'b0, 8'h11, 8'h70, 8'h00, 1'b0, 1'b0, 8'hFF);
    checks++;
    if (o !== e) begin errors++; $display("FAIL redir_beats_start: got %h required %h", o, e); end
  endtask

  task automatic test_wrap();
    logic [34:0] o;
    logic [34:0] e;
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    o = observe(); e = bundle(1'b1, 8'hFF, 8'h80, 8'h01, 1'b1, 1'b0, 8'h01);
    checks++;
    if (o !== e) begin errors++; $display("FAIL wrap_imm: got %h required %h", o, e); end
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    o = observe(); e = bundle(1'b1, 8'h01, 8'h80, 8'hFF, 1'b1, 1'b0, 8'h03);
    checks++;
    if (o !== e) begin errors++; $display("FAIL wrap_next: got %h required %h", o, e); end
  endtask

  task automatic test_reset_stall();
    logic [34:0] o;
    logic [34:0] e;
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b0;
    cyc(1'b1, 1'b1, 8'h20, 1'b0);
    o = observe(); e = bundle(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    checks++;
    if (o !== e) begin errors++; $display("FAIL reset_stall: got %h required %h", o, e); end
    rst_n = 1'b1;
    // IDLE ignores a jump and does not fetch without start.
    cyc(1'b0, 1'b1, 8'h40, 1'b1);
    o = observe();
    checks++;
    if (o !== e) begin errors++; $display("FAIL idle_jmp: got %h required %h", o, e); end
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    o = observe();
    checks++;
    if (o !== e) begin errors++; $display("FAIL idle_hold: got %h required %h", o, e); end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    jmp_en    = 1'b0;
    jmp_addr  = 8'h00;
    out_ready = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    // Encodings: NOP 0x0x, WO 0x3x, HLT 0x7x, ADDI 0x8x (two bytes).
    rom[8'h00] = 8'h01;
    rom[8'h01] = 8'h80;
    rom[8'h02] = 8'hFF;
    rom[8'h03] = 8'h30;
    rom[8'h04] = 8'h02;
    rom[8'h05] = 8'h70;
    rom[8'h06] = 8'h30;
    rom[8'h10] = 8'h31;
    rom[8'h11] = 8'h70;
    rom[8'hFF] = 8'h80;

    test_reset();
    test_stream_stall();
    test_halt();
    test_redirect();
    test_wrap();
    test_reset_stall();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch sequencer for the 8-bit core. Owns the program counter, drives the address of the combinational instruction ROM and captures opcode plus immediate byte each cycle. Presents one decoded-length instruction at a time to the decoder over a valid/ready handshake. Handles start, jump redirect and halt-on-HLT; sits between the instruction ROM and the decode/execute stage.

## Interface
- WORD, default 8: data and address width.
- RESET_PC, default 0: PC value after reset.
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  leave IDLE or HALT and fetch from current PC.
- jmp_en  in  1  redirect request from execute, single-cycle pulse.
- jmp_addr  in  WORD  redirect target.
- mem_addr  out  WORD  ROM address; combinational, equals PC.
- mem_instr  in  WORD  ROM byte at mem_addr, same cycle.
- mem_imm  in  WORD  ROM byte at mem_addr+1 (mod 2^WORD), same cycle.
- out_valid  out  1  instruction bundle valid.
- out_ready  in  1  decoder accepts bundle.
- out_instr  out  WORD  registered opcode byte.
- out_imm  out  WORD  registered immediate; 0 when out_has_imm=0.
- out_has_imm  out  1  instruction is two bytes.
- out_pc  out  WORD  address of out_instr.
- halted  out  1  high in HALT state.

## Operation
- States: IDLE, RUN, HALT. Reset: state=IDLE, PC=RESET_PC, out_valid=0, out_instr/out_imm/out_pc=0, out_has_imm=0, halted=0.
- IDLE: no fetch; start -> RUN. jmp_en ignored.
- Load condition: state==RUN && !jmp_en && (!out_valid || out_ready). On load: out_instr<=mem_instr, out_pc<=PC, out_has_imm<=op_has_imm(mem_instr), out_imm<=has_imm ? mem_imm : 0, out_valid<=1, PC<=PC+(has_imm?2:1).
- RUN with out_valid && out_ready && no load possible (never in RUN) — n/a; outside RUN, out_ready with out_valid clears out_valid.
- Stall: out_valid && !out_ready -> all outputs and PC held stable.
- Halt: if loaded opcode satisfies op_is_halt, state -> HALT same edge; HLT bundle is still presented; PC points past it. HALT: no fetch; start -> RUN.
- Redirect (RUN or HALT): jmp_en -> PC<=jmp_addr, out_valid<=0 (pending bundle discarded, accepted or not), state<=RUN. Redirect beats start and load.
- Arithmetic: PC is WORD bits, wraps modulo 2^WORD; imm of a two-byte instruction at 0xFF comes from 0x00, next PC 0x01.

## Timing
- start sampled at edge N -> RUN; first load at edge N+1; out_valid high after N+1.
- Throughput 1 bundle/cycle while out_ready=1.
- jmp_en at edge N -> out_valid=0 after N; target bundle valid after N+1 (one-cycle bubble).
- rst_n low at any edge overrides everything, including mid-stall and redirect.
- halted is registered, rises on the edge that loads HLT.

## Structure
- project_pkg gains: opcode field slice constants, op_has_imm() and op_is_halt() functions, fetch_state_e enum {IDLE, RUN, HALT}.
- No sub-module; instr_mem is instantiated beside this block at core top and wired by mem_addr/mem_instr/mem_imm.

## Test plan
- Reset then start, ROM {NOP, ADDI, 0xFF, WO}, out_ready=1 -> bundles (pc0,NOP,imm0), (pc1,ADDI,imm0xFF,has_imm), (pc3,WO); first valid 2 cycles after start.
- Hold out_ready=0 for 3 cycles on ADDI bundle -> out_* and mem_addr constant; releases to WO next cycle.
- jmp_en to 0x10 while a bundle is stalled -> out_valid=0 next cycle, bundle pc=0x10 following cycle; jmp_en+start together -> redirect wins.
- HLT at 0x05 -> HLT bundle emitted, halted=1, no further bundles; start -> fetch resumes at 0x06.
- ADDI at 0xFF -> out_imm=rom[0x00], next bundle pc=0x01.
- rst_n low during stall -> after edge out_valid=0, state IDLE, mem_addr=RESET_PC.
